// File: rtl/pio_gpio_output_arbiter.sv
// PIO output arbiter: fixed-priority FSM merge per core, then per-pin core routing, all registered.
// Optional PIO_CONFLICT_DETECT_EN flags cycles where several FSMs of one core drive the same pin.
module pio_gpio_output_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NUM_FSMS  = 4,
  parameter int unsigned NUM_PINS  = 32,
  localparam int unsigned SEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_output,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_drive,
  input  logic [NUM_PINS*SEL_W-1:0]              core_select,
  output logic [NUM_CORES*NUM_PINS-1:0]          core_output,
  output logic [NUM_CORES*NUM_PINS-1:0]          core_drive,
  output logic [NUM_PINS-1:0]                    gpio_output,
  output logic [NUM_PINS-1:0]                    gpio_drive,
  output logic [NUM_CORES*NUM_PINS-1:0]          fsm_conflict
);

  logic [NUM_CORES*NUM_PINS-1:0] merge_out_d, merge_drive_d;
  logic [NUM_CORES*NUM_PINS-1:0] core_output_q, core_drive_q;
  logic [NUM_PINS-1:0]           gpio_output_d, gpio_drive_d;
  logic [NUM_PINS-1:0]           gpio_output_q, gpio_drive_q;
  logic [SEL_W-1:0]              sel;

`ifdef PIO_CONFLICT_DETECT_EN
  logic [NUM_CORES*NUM_PINS-1:0] conflict_d, conflict_q;
`endif

  // Ascending scan: a later (higher-numbered) driving FSM overwrites earlier ones.
  always_comb begin
    merge_out_d   = '0;
    merge_drive_d = '0;
`ifdef PIO_CONFLICT_DETECT_EN
    conflict_d    = '0;
`endif
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      for (int p = 0; p < int'(NUM_PINS); p++) begin
        for (int f = 0; f < int'(NUM_FSMS); f++) begin
          if (fsm_drive[(c*int'(NUM_FSMS)+f)*int'(NUM_PINS)+p]) begin
`ifdef PIO_CONFLICT_DETECT_EN
            // A driver already seen means at least two FSMs contend for this pin.
            conflict_d[c*int'(NUM_PINS)+p] = conflict_d[c*int'(NUM_PINS)+p]
                                           | merge_drive_d[c*int'(NUM_PINS)+p];
`endif
            merge_out_d[c*int'(NUM_PINS)+p]   = fsm_output[(c*int'(NUM_FSMS)+f)*int'(NUM_PINS)+p];
            merge_drive_d[c*int'(NUM_PINS)+p] = 1'b1;
          end
        end
      end
    end
  end

  // Routing reads the combinational merge so both stages land on the same edge.
  always_comb begin
    gpio_output_d = '0;
    gpio_drive_d  = '0;
    sel           = '0;
    for (int p = 0; p < int'(NUM_PINS); p++) begin
      sel = core_select[p*int'(SEL_W) +: SEL_W];
      if (32'(sel) < NUM_CORES) begin
        gpio_output_d[p] = merge_out_d[32'(sel)*NUM_PINS+32'(p)];
        gpio_drive_d[p]  = merge_drive_d[32'(sel)*NUM_PINS+32'(p)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_output_q <= '0;
      core_drive_q  <= '0;
      gpio_output_q <= '0;
      gpio_drive_q  <= '0;
    end else begin
      core_output_q <= merge_out_d;
      core_drive_q  <= merge_drive_d;
      gpio_output_q <= gpio_output_d;
      gpio_drive_q  <= gpio_drive_d;
    end
  end

`ifdef PIO_CONFLICT_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign fsm_conflict = conflict_q;
`else
  assign fsm_conflict = '0;
`endif

  assign core_output = core_output_q;
  assign core_drive  = core_drive_q;
  assign gpio_output = gpio_output_q;
  assign gpio_drive  = gpio_drive_q;

endmodule

// File: tb/tb_pio_gpio_output_arbiter.sv
// Randomised bench for pio_gpio_output_arbiter: per-cycle comparison against a behavioural model
// plus directed literal checks for priority, undriven, routing, wrong owner, latency and reset.
module tb_pio_gpio_output_arbiter;
  localparam int NC  = 4;
  localparam int NF  = 4;
  localparam int NP  = 32;
  localparam int SW  = 2;
  localparam int TOT = NC * NF * NP;
  localparam int CP  = NC * NP;

  typedef struct packed {
    logic [CP-1:0] co;
    logic [CP-1:0] cd;
    logic [CP-1:0] cf;
    logic [NP-1:0] go;
    logic [NP-1:0] gd;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [TOT-1:0] fsm_output, fsm_drive;
  logic [NP*SW-1:0] core_select;
  logic [CP-1:0]  core_output, core_drive, fsm_conflict;
  logic [NP-1:0]  gpio_output, gpio_drive;

  int   nchk  = 0;
  int   nfail = 0;
  logic chk_en = 1'b0;
  exp_t exp_q;

  pio_gpio_output_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .fsm_output  (fsm_output),
    .fsm_drive   (fsm_drive),
    .core_select (core_select),
    .core_output (core_output),
    .core_drive  (core_drive),
    .gpio_output (gpio_output),
    .gpio_drive  (gpio_drive),
    .fsm_conflict(fsm_conflict)
  );

  always #5 clk = ~clk;

  // Spec-level model: count drivers, take the highest-numbered one, then look up the owner core.
  function automatic exp_t model(input logic [TOT-1:0] fo, input logic [TOT-1:0] fd,
                                 input logic [NP*SW-1:0] sel);
    exp_t e;
    int   n;
    int   s;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) begin
        n = 0;
        for (int f = NF - 1; f >= 0; f--) begin
          if (fd[(c*NF+f)*NP+p]) begin
            n++;
            if (n == 1) e.co[c*NP+p] = fo[(c*NF+f)*NP+p];
          end
        end
        e.cd[c*NP+p] = (n > 0);
`ifdef PIO_CONFLICT_DETECT_EN
        e.cf[c*NP+p] = (n >= 2);
`endif
      end
    end
    for (int p = 0; p < NP; p++) begin
      s = int'(sel[p*SW +: SW]);
      if (s < NC) begin
        e.go[p] = e.co[s*NP+p];
        e.gd[p] = e.cd[s*NP+p];
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [CP-1:0] act, input logic [CP-1:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) exp_q <= '0;
    else      exp_q <= model(fsm_output, fsm_drive, core_select);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_output", core_output, exp_q.co);
      check("core_drive", core_drive, exp_q.cd);
      check("fsm_conflict", fsm_conflict, exp_q.cf);
      check("gpio_output", CP'(gpio_output), CP'(exp_q.go));
      check("gpio_drive", CP'(gpio_drive), CP'(exp_q.gd));
    end
  end

  task automatic rand_inputs(input bit sparse);
    for (int i = 0; i < TOT / 32; i++) begin
      fsm_output[i*32 +: 32] = $urandom;
      fsm_drive[i*32 +: 32]  = sparse ? ($urandom & $urandom & $urandom) : $urandom;
    end
    for (int i = 0; i < NP * SW / 32; i++) core_select[i*32 +: 32] = $urandom;
  endtask

  task automatic clear_inputs();
    fsm_output  = '0;
    fsm_drive   = '0;
    core_select = '0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_core_output"}, core_output, '0);
    check({name, "_core_drive"}, core_drive, '0);
    check({name, "_gpio"}, CP'({gpio_output, gpio_drive}), '0);
    check({name, "_conflict"}, fsm_conflict, '0);
  endtask

  initial begin
    rst = 1'b1;
    rand_inputs(1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    chk_en = 1'b1;
    @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b1;

    // Priority: FSM3 (value 0) beats FSM1 (value 1) on core0 pin5.
    clear_inputs();
    fsm_drive[1*NP+5] = 1'b1; fsm_output[1*NP+5] = 1'b1;
    fsm_drive[3*NP+5] = 1'b1; fsm_output[3*NP+5] = 1'b0;
    @(negedge clk);
    check("prio_core_output5", CP'(core_output[5]), CP'(1'b0));
    check("prio_core_drive5", CP'(core_drive[5]), CP'(1'b1));
`ifdef PIO_CONFLICT_DETECT_EN
    check("prio_conflict5", CP'(fsm_conflict[5]), CP'(1'b1));
`else
    check("prio_conflict5", CP'(fsm_conflict[5]), CP'(1'b0));
`endif

    // Undriven: core2 values all 1, no drives.
    clear_inputs();
    fsm_output = '1;
    @(negedge clk);
    check("undriven_core2_out", CP'(core_output[2*NP +: NP]), '0);
    check("undriven_core2_drv", CP'(core_drive[2*NP +: NP]), '0);

    // Routing: pin0 owned by core1 (value 1), pin1 by core3 (value 0).
    clear_inputs();
    core_select[0*SW +: SW] = 2'd1;
    core_select[1*SW +: SW] = 2'd3;
    fsm_drive[(1*NF+0)*NP+0]  = 1'b1; fsm_output[(1*NF+0)*NP+0]  = 1'b1;
    fsm_drive[(3*NF+0)*NP+1]  = 1'b1; fsm_output[(3*NF+0)*NP+1]  = 1'b0;
    @(negedge clk);
    check("route_gpio_drive", CP'(gpio_drive[1:0]), CP'(2'b11));
    check("route_gpio_output", CP'(gpio_output[1:0]), CP'(2'b01));

    // Wrong owner: core0 drives pin7 but core2 owns it.
    clear_inputs();
    core_select[7*SW +: SW] = 2'd2;
    fsm_drive[7] = 1'b1; fsm_output[7] = 1'b1;
    @(negedge clk);
    check("owner_gpio_drive7", CP'(gpio_drive[7]), CP'(1'b0));
    check("owner_gpio_output7", CP'(gpio_output[7]), CP'(1'b0));
    check("owner_core0_drive7", CP'(core_drive[7]), CP'(1'b1));

    // Latency: toggle core0/FSM0/pin0 drive each cycle; reset pulse in the middle.
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      fsm_drive[0] = i[0];
      @(posedge clk);
      if (i == 5) begin
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
        check("latency_gpio_drive0", CP'(gpio_drive[0]), CP'(i[0]));
      end
    end

    // Randomised traffic, mostly sparse drives so priority and undriven cases both occur.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(($urandom % 4) != 0);
      @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
